// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with an in-order request/response memory port
//   and a small {pc, inst} buffer feeding the IF register.
// Build option: define FETCH_PREFETCH_EN for a 2-deep buffer (back-to-back fetch);
//   left undefined, one instruction is either in flight or buffered.
// Ports:
//   clk, rst (async, active-high)
//   stall                   hold the head instruction
//   redirect, redirect_pc   taken branch/jump; flushes the buffer and refetches
//   imem_req/addr/gnt       request channel (accepted when req & gnt)
//   imem_rvalid/rdata       in-order response channel
//   PC_out/inst_out/inst_valid  head of the buffer (NOP_INST when empty)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_out,
   output logic [31:0] inst_out,
   output logic        inst_valid
);
`ifdef FETCH_PREFETCH_EN
   localparam int D = 2;
`else
   localparam int D = 1;
`endif
   localparam logic [1:0] DL = 2'(D);
   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
   state_t state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0] out_q, out_d, drop_q, drop_d, occ_q, occ_d, live;
   logic [31:0] pcq_q [D];
   logic [31:0] pcq_d [D];
   logic [31:0] fpc_q [D];
   logic [31:0] fpc_d [D];
   logic [31:0] finst_q [D];
   logic [31:0] finst_d [D];
   logic pop, credit, grant, rv, stale_rv, live_rv, push, unused;
   always_comb begin
      inst_valid = occ_q != 2'd0;
      PC_out = inst_valid ? fpc_q[0] : fetch_pc_q;
      inst_out = inst_valid ? finst_q[0] : NOP_INST;
      imem_addr = fetch_pc_q;
      pop = inst_valid && !stall && !redirect;
`ifdef FETCH_PREFETCH_EN
      // the slot vacated by this cycle's pop can already be reissued
      credit = pop;
`else
      credit = 1'b0;
`endif
      imem_req = state_q == RUN && out_q + occ_q - {1'b0, credit} < DL;
      grant = imem_req && imem_gnt;
      rv = imem_rvalid && out_q != 2'd0;
      stale_rv = rv && drop_q != 2'd0;
      live_rv = rv && drop_q == 2'd0;
      push = live_rv && !redirect;
      // pc queue holds only the requests whose responses are still wanted
      live = out_q - drop_q;
      unused = ^redirect_pc[1:0];
      pcq_d = pcq_q;
      fpc_d = fpc_q;
      finst_d = finst_q;
      if (live_rv)
         for (int i = 0; i < D - 1; i++) pcq_d[i] = pcq_q[i + 1];
      for (int i = 0; i < D; i++)
         if (grant && i == int'(live - {1'b0, live_rv})) pcq_d[i] = fetch_pc_q;
      if (pop)
         for (int i = 0; i < D - 1; i++) begin
            fpc_d[i] = fpc_q[i + 1];
            finst_d[i] = finst_q[i + 1];
         end
      for (int i = 0; i < D; i++)
         if (push && i == int'(occ_q - {1'b0, pop})) begin
            fpc_d[i] = pcq_q[0];
            finst_d[i] = imem_rdata;
         end
      occ_d = redirect ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
      out_d = out_q + {1'b0, grant} - {1'b0, rv};
      // on redirect everything still in flight after this edge is stale
      drop_d = redirect ? out_d : drop_q - {1'b0, stale_rv};
      fetch_pc_d = redirect ? {redirect_pc[31:2], 2'b00} : grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
      state_d = redirect ? (out_d != 2'd0 ? FLUSH : RUN) :
                state_q == BOOT ? RUN :
                state_q == FLUSH && drop_d == 2'd0 ? RUN : state_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         fetch_pc_q <= RESET_PC;
         out_q <= 2'd0;
         drop_q <= 2'd0;
         occ_q <= 2'd0;
         for (int i = 0; i < D; i++) begin
            pcq_q[i] <= '0;
            fpc_q[i] <= '0;
            finst_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         fetch_pc_q <= fetch_pc_d;
         out_q <= out_d;
         drop_q <= drop_d;
         occ_q <= occ_d;
         pcq_q <= pcq_d;
         fpc_q <= fpc_d;
         finst_q <= finst_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory and a queue-based reference model
module tb_fetch_unit;
`ifdef FETCH_PREFETCH_EN
   localparam int D = 2;
`else
   localparam int D = 1;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] redirect_pc = '0, imem_rdata = '0;
   logic imem_req, inst_valid;
   logic [31:0] imem_addr, PC_out, inst_out;
   fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .PC_out(PC_out), .inst_out(inst_out), .inst_valid(inst_valid)
   );
   always #5 clk = ~clk;
   int passed = 0, total = 0, cyc = 0, lat = 1;
   bit gnt_en = 1'b1;
   int mem_due[$];
   logic [31:0] mem_addr[$];
   bit m_boot;
   logic [31:0] m_pc;
   int m_stale;
   logic [31:0] m_fly[$], b_pc[$], b_inst[$];
   logic tr_req [1024];
   logic tr_valid [1024];
   logic [31:0] tr_addr [1024], tr_pc [1024], tr_inst [1024];
   function automatic logic [31:0] word(input logic [31:0] a);
      return {8'hA5, a[23:0]};
   endfunction
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst_out, NOP);
      chk("rst_pc", PC_out, 32'h0);
      mem_due.delete();
      mem_addr.delete();
      m_boot = 1'b1;
      m_pc = 32'h0;
      m_stale = 0;
      m_fly.delete();
      b_pc.delete();
      b_inst.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask
   // one cycle: drive memory side, compare against the model, advance the model, move to next negedge
   task automatic step();
      logic e_valid, e_req, pop, rv;
      logic [31:0] e_pc, e_inst, rpc;
      rv = mem_due.size() > 0 && mem_due[0] <= cyc;
      imem_rvalid = rv;
      imem_rdata = rv ? word(mem_addr[0]) : 32'h0;
      imem_gnt = gnt_en;
      #1;
      e_valid = b_pc.size() > 0;
      e_pc = e_valid ? b_pc[0] : m_pc;
      e_inst = e_valid ? b_inst[0] : NOP;
      pop = e_valid && !stall && !redirect;
      e_req = !m_boot && m_stale == 0 &&
              (m_fly.size() + b_pc.size() - ((D > 1 && pop) ? 1 : 0)) < D;
      chk("inst_valid", inst_valid, e_valid);
      chk("PC_out", PC_out, e_pc);
      chk("inst_out", inst_out, e_inst);
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, m_pc);
`ifndef FETCH_PREFETCH_EN
      if (imem_req) chk("req_while_busy", m_fly.size() + b_pc.size(), 0);
`endif
      if (cyc < 1024) begin
         tr_req[cyc] = imem_req;
         tr_valid[cyc] = inst_valid;
         tr_addr[cyc] = imem_addr;
         tr_pc[cyc] = PC_out;
         tr_inst[cyc] = inst_out;
      end
      if (pop) begin
         void'(b_pc.pop_front());
         void'(b_inst.pop_front());
      end
      if (rv) begin
         if (m_stale > 0) m_stale--;
         else if (m_fly.size() > 0) begin
            rpc = m_fly.pop_front();
            if (!redirect) begin
               b_pc.push_back(rpc);
               b_inst.push_back(word(rpc));
            end
         end
         void'(mem_due.pop_front());
         void'(mem_addr.pop_front());
      end
      if (e_req && gnt_en) begin
         m_fly.push_back(m_pc);
         m_pc += 32'd4;
      end
      if (redirect) begin
         b_pc.delete();
         b_inst.delete();
         m_stale += m_fly.size();
         m_fly.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
      end
      m_boot = 1'b0;
      if (imem_req && imem_gnt) begin
         mem_due.push_back(cyc + lat);
         mem_addr.push_back(imem_addr);
      end
      cyc++;
      @(negedge clk);
   endtask
   initial begin
      int b;
      do_reset();
      // streaming start-up, then a 5-cycle stall while the head is 0x4
      b = cyc;
      repeat (4) step();
      stall = 1'b1;
      repeat (5) step();
      stall = 1'b0;
      repeat (4) step();
      chk("boot_no_req", tr_req[b], 0);
      chk("first_req", tr_req[b+1], 1);
      chk("first_addr", tr_addr[b+1], 32'h0);
`ifdef FETCH_PREFETCH_EN
      chk("req_c2", tr_req[b+2], 1);
      chk("addr_c2", tr_addr[b+2], 32'h4);
      chk("req_c3", tr_req[b+3], 1);
      chk("addr_c3", tr_addr[b+3], 32'h8);
      chk("valid_c2", tr_valid[b+2], 0);
      chk("valid_c3", tr_valid[b+3], 1);
      chk("pc_c3", tr_pc[b+3], 32'h0);
      for (int k = 4; k <= 8; k++) chk("stall_head_pc", tr_pc[b+k], 32'h4);
      chk("stall_req_c5", tr_req[b+5], 0);
      chk("stall_req_c8", tr_req[b+8], 0);
      chk("release_pc_c9", tr_pc[b+9], 32'h4);
      chk("release_pc_c10", tr_pc[b+10], 32'h8);
      chk("release_pc_c11", tr_pc[b+11], 32'hC);
      chk("release_valid_c11", tr_valid[b+11], 1);
`else
      chk("d1_req_c2", tr_req[b+2], 0);
      chk("d1_req_c3", tr_req[b+3], 0);
      chk("d1_valid_c3", tr_valid[b+3], 1);
      chk("d1_pc_c3", tr_pc[b+3], 32'h0);
      chk("d1_req_c4", tr_req[b+4], 1);
      chk("d1_addr_c4", tr_addr[b+4], 32'h4);
`endif
      // redirect to 0x100 while requests are in flight (slow memory)
      do_reset();
      lat = 3;
      b = cyc;
      repeat (3) step();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      repeat (8) step();
`ifdef FETCH_PREFETCH_EN
      chk("two_out_req_c3", tr_req[b+3], 0);
      for (int k = 4; k <= 9; k++) chk("flush_valid_low", tr_valid[b+k], 0);
      chk("flush_req_c4", tr_req[b+4], 0);
      chk("flush_req_c5", tr_req[b+5], 0);
      chk("target_req_c6", tr_req[b+6], 1);
      chk("target_addr_c6", tr_addr[b+6], 32'h100);
      chk("target_pc_c10", tr_pc[b+10], 32'h100);
      chk("target_valid_c10", tr_valid[b+10], 1);
      chk("target_inst_c10", tr_inst[b+10], 32'hA500_0100);
`else
      chk("d1_flush_req_c4", tr_req[b+4], 0);
      chk("d1_target_addr_c5", tr_addr[b+5], 32'h100);
      chk("d1_valid_c8", tr_valid[b+8], 0);
      chk("d1_target_pc_c9", tr_pc[b+9], 32'h100);
      chk("d1_target_valid_c9", tr_valid[b+9], 1);
`endif
      // redirect coinciding with stall (and, with prefetch, a live response)
      do_reset();
      lat = 1;
      b = cyc;
      repeat (3) step();
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h100;
      step();
      stall = 1'b0;
      redirect = 1'b0;
      repeat (4) step();
      chk("coinc_req_c3", tr_req[b+3], 0);
      chk("coinc_valid_c3", tr_valid[b+3], 1);
      chk("coinc_valid_c4", tr_valid[b+4], 0);
      chk("coinc_pc_c4", tr_pc[b+4], 32'h100);
      chk("coinc_req_c4", tr_req[b+4], 1);
      chk("coinc_addr_c4", tr_addr[b+4], 32'h100);
      // unaligned redirect target during the boot cycle
      do_reset();
      b = cyc;
      redirect = 1'b1;
      redirect_pc = 32'h202;
      step();
      redirect = 1'b0;
      repeat (4) step();
      chk("align_req", tr_req[b+1], 1);
      chk("align_addr", tr_addr[b+1], 32'h200);
      chk("align_pc", tr_pc[b+1], 32'h200);
      chk("align_head_pc", tr_pc[b+3], 32'h200);
      chk("align_head_inst", tr_inst[b+3], 32'hA500_0200);
      // reset while requests are outstanding, then a long mixed pattern
      repeat (2) step();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         gnt_en = (i % 3) != 2;
         stall = (i % 7) == 3 || (i % 7) == 4;
         redirect = (i % 23) == 11;
         redirect_pc = 32'h400 + 32'(i * 8) + 32'(i % 4);
         lat = 1 + (i / 50) % 3;
         step();
      end
      redirect = 1'b0;
      stall = 1'b0;
      gnt_en = 1'b1;
      repeat (10) step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
